// File: rtl/pico_pkg.sv
// Shared machine constants for the pico core: datapath width, register count,
// reserved register numbers and the writeback request record.
package pico;

  localparam int N  = 16;
  localparam int R  = 8;
  localparam int AW = $clog2(R);

  localparam logic [AW-1:0] ZERO_REG = AW'(0);
  localparam logic [AW-1:0] EXT_REG  = AW'(4);

  typedef struct packed {
    logic [AW-1:0]       addr;
    logic signed [N-1:0] data;
  } wb_req_t;

  // Registers that silently swallow writes (hard-wired zero, external input).
  function automatic logic is_reserved(input logic [AW-1:0] a);
    return (a == ZERO_REG) || (a == EXT_REG);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on contention the requester not granted last wins.
// gnt[0] is requester A, gnt[1] is requester B.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_b;

  assign gnt[0] = req[0] & (~req[1] | last_b);
  assign gnt[1] = req[1] & (~req[0] | ~last_b);

  // Reset leaves B as last winner so A takes the first contention.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_b <= 1'b1;
    end else if (|gnt) begin
      last_b <= gnt[1];
    end
  end

endmodule

// File: rtl/rf_wb_arb.sv
// Register-file writeback arbiter: merges ALU and load/IO writebacks into one
// registered write port, drops writes to reserved registers, forwards in-flight data.
module rf_wb_arb
  import pico::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                a_valid_i,
  output logic                a_ready_o,
  input  logic [AW-1:0]       a_addr_i,
  input  logic signed [N-1:0] a_data_i,
  input  logic                b_valid_i,
  output logic                b_ready_o,
  input  logic [AW-1:0]       b_addr_i,
  input  logic signed [N-1:0] b_data_i,
  input  logic                stall_i,
  output logic                wr_en_o,
  output logic [AW-1:0]       wr_addr_o,
  output logic signed [N-1:0] wr_data_o,
  input  logic [AW-1:0]       byp_addr_i,
  output logic                byp_hit_o,
  output logic signed [N-1:0] byp_data_o,
  output logic [7:0]          drop_cnt_o
);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [1:0]          req_p0;
  logic [1:0]          gnt_p0;
  wb_req_t             a_req_p0;
  wb_req_t             b_req_p0;
  wb_req_t             sel_p0;
  logic                acc_p0;
  logic                drop_p0;
  logic                issue_p0;

  logic                vld_p1;
  logic [AW-1:0]       addr_p1;
  logic signed [N-1:0] data_p1;
  logic [7:0]          drop_cnt_q;

  // Stage p0: arbitration and acceptance
  assign req_p0 = {b_valid_i, a_valid_i} & {2{rst_ni & ~stall_i}};

  rr_arb2 u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req    (req_p0),
    .gnt    (gnt_p0)
  );

  assign a_ready_o = gnt_p0[0];
  assign b_ready_o = gnt_p0[1];

  assign a_req_p0 = '{addr: a_addr_i, data: a_data_i};
  assign b_req_p0 = '{addr: b_addr_i, data: b_data_i};
  assign sel_p0   = gnt_p0[1] ? b_req_p0 : a_req_p0;

  assign acc_p0   = |gnt_p0;
  assign drop_p0  = acc_p0 & is_reserved(sel_p0.addr);
  assign issue_p0 = acc_p0 & ~drop_p0;

  // Stage p1: output register, drained every cycle
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_p1     <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      vld_p1 <= issue_p0;
      if (drop_p0) begin
        drop_cnt_q <= sat_inc8(drop_cnt_q);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (issue_p0) begin
      addr_p1 <= sel_p0.addr;
      data_p1 <= sel_p0.data;
    end
  end

  // Data registers carry no reset; the valid bit masks them onto the port.
  assign wr_en_o    = vld_p1 & rst_ni;
  assign wr_addr_o  = wr_en_o ? addr_p1 : '0;
  assign wr_data_o  = wr_en_o ? data_p1 : '0;
  assign byp_hit_o  = wr_en_o && (addr_p1 == byp_addr_i);
  assign byp_data_o = byp_hit_o ? data_p1 : '0;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_rf_wb_arb.sv
// Bench for rf_wb_arb: directed scenarios plus randomized traffic against a
// transaction-level model of arbitration, one-deep write stage and drop counter.
module tb_rf_wb_arb;
  import pico::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_ni = 1'b0;
  logic                a_valid_i = 1'b0, b_valid_i = 1'b0, stall_i = 1'b0;
  logic [AW-1:0]       a_addr_i = '0, b_addr_i = '0, byp_addr_i = '0;
  logic signed [N-1:0] a_data_i = '0, b_data_i = '0;
  logic                a_ready_o, b_ready_o, wr_en_o, byp_hit_o;
  logic [AW-1:0]       wr_addr_o;
  logic signed [N-1:0] wr_data_o, byp_data_o;
  logic [7:0]          drop_cnt_o;

  rf_wb_arb dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .a_valid_i  (a_valid_i),
    .a_ready_o  (a_ready_o),
    .a_addr_i   (a_addr_i),
    .a_data_i   (a_data_i),
    .b_valid_i  (b_valid_i),
    .b_ready_o  (b_ready_o),
    .b_addr_i   (b_addr_i),
    .b_data_i   (b_data_i),
    .stall_i    (stall_i),
    .wr_en_o    (wr_en_o),
    .wr_addr_o  (wr_addr_o),
    .wr_data_o  (wr_data_o),
    .byp_addr_i (byp_addr_i),
    .byp_hit_o  (byp_hit_o),
    .byp_data_o (byp_data_o),
    .drop_cnt_o (drop_cnt_o)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference state: who won last, the single pending write, dropped-write tally.
  bit                  m_last_b = 1'b1;
  bit                  m_vld    = 1'b0;
  logic [AW-1:0]       m_addr   = '0;
  logic signed [N-1:0] m_data   = '0;
  int                  m_drop   = 0;

  logic                o_ar, o_br, o_en, o_hit;
  logic [AW-1:0]       o_addr;
  logic signed [N-1:0] o_data, o_byp;
  logic [7:0]          o_drop;

  logic                e_ar, e_br, e_en, e_hit;
  logic [AW-1:0]       e_addr;
  logic signed [N-1:0] e_data, e_byp;
  logic [7:0]          e_drop;

  // One clock: apply inputs after the falling edge, capture outputs, predict, advance.
  task automatic tick(input logic av, input logic [AW-1:0] aa, input logic signed [N-1:0] ad,
                      input logic bv, input logic [AW-1:0] ba, input logic signed [N-1:0] bd,
                      input logic st, input logic rn, input logic [AW-1:0] qa);
    logic [AW-1:0]       na;
    logic signed [N-1:0] nd;
    a_valid_i = av; a_addr_i = aa; a_data_i = ad;
    b_valid_i = bv; b_addr_i = ba; b_data_i = bd;
    stall_i = st; rst_ni = rn; byp_addr_i = qa;
    #1;
    o_ar = a_ready_o; o_br = b_ready_o; o_en = wr_en_o; o_addr = wr_addr_o;
    o_data = wr_data_o; o_hit = byp_hit_o; o_byp = byp_data_o; o_drop = drop_cnt_o;
    e_ar   = rn && !st && av && (!bv || m_last_b);
    e_br   = rn && !st && bv && (!av || !m_last_b);
    e_en   = rn && m_vld;
    e_addr = e_en ? m_addr : '0;
    e_data = e_en ? m_data : '0;
    e_hit  = e_en && (m_addr == qa);
    e_byp  = e_hit ? m_data : '0;
    e_drop = 8'(m_drop);
    @(posedge clk);
    if (!rn) begin
      m_vld = 0; m_drop = 0; m_last_b = 1;
    end else if (e_ar || e_br) begin
      m_last_b = e_br;
      na = e_br ? ba : aa;
      nd = e_br ? bd : ad;
      if (na == 0 || na == 4) begin
        m_vld = 0;
        if (m_drop < 255) m_drop = m_drop + 1;
      end else begin
        m_vld = 1; m_addr = na; m_data = nd;
      end
    end else begin
      m_vld = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic [AW-1:0] qa);
    tick(0, 0, 0, 0, 0, 0, 0, 1, qa);
  endtask

  task automatic do_reset();
    tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    tick(1, 3, 16'sh1, 1, 2, 16'sh2, 0, 0, 3);
    tick(1, 3, 16'sh1, 1, 2, 16'sh2, 0, 0, 3);
    n_checks++; if (o_ar !== 1'b0 || o_br !== 1'b0) begin n_err++;
      $display("FAIL reset_ready: got a=%0b b=%0b want 0 0", o_ar, o_br); end
    n_checks++; if (o_en !== 1'b0 || o_addr !== '0 || o_data !== '0) begin n_err++;
      $display("FAIL reset_wr: got en=%0b addr=%0d data=%0h want 0 0 0", o_en, o_addr, o_data); end
    n_checks++; if (o_drop !== 8'd0) begin n_err++;
      $display("FAIL reset_drop: got %0d want 0", o_drop); end
    n_checks++; if (o_hit !== 1'b0) begin n_err++;
      $display("FAIL reset_byp: got %0b want 0", o_hit); end
  endtask

  task automatic test_single();
    tick(1, 3, 16'sh5A, 0, 0, 0, 0, 1, 3);
    n_checks++; if (o_ar !== 1'b1 || o_en !== 1'b0) begin n_err++;
      $display("FAIL single_accept: got ready=%0b en=%0b want 1 0", o_ar, o_en); end
    idle(3);
    n_checks++; if (o_en !== 1'b1 || o_addr !== 3'd3 || o_data !== 16'sh5A) begin n_err++;
      $display("FAIL single_write: got en=%0b addr=%0d data=%0h want 1 3 5a", o_en, o_addr, o_data); end
    n_checks++; if (o_hit !== 1'b1 || o_byp !== 16'sh5A) begin n_err++;
      $display("FAIL single_byp: got hit=%0b data=%0h want 1 5a", o_hit, o_byp); end
    idle(3);
    n_checks++; if (o_en !== 1'b0 || o_addr !== '0 || o_hit !== 1'b0) begin n_err++;
      $display("FAIL single_after: got en=%0b addr=%0d hit=%0b want 0 0 0", o_en, o_addr, o_hit); end
  endtask

  task automatic test_alternate();
    logic [AW-1:0] want;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1, 1, 16'(16'h100 + i), 1, 2, 16'(16'h200 + i), 0, 1, 0);
      n_checks++; if (o_ar !== ((i % 2) == 0) || o_br !== ((i % 2) == 1)) begin n_err++;
        $display("FAIL alt_grant%0d: got a=%0b b=%0b want a=%0b", i, o_ar, o_br, (i % 2) == 0); end
      if (i > 0) begin
        want = ((i - 1) % 2 == 0) ? 3'd1 : 3'd2;
        n_checks++; if (o_en !== 1'b1 || o_addr !== want) begin n_err++;
          $display("FAIL alt_write%0d: got en=%0b addr=%0d want 1 %0d", i, o_en, o_addr, want); end
      end
    end
    idle(0);
    n_checks++; if (o_en !== 1'b1 || o_addr !== 3'd2 || o_data !== 16'sh203) begin n_err++;
      $display("FAIL alt_last: got en=%0b addr=%0d data=%0h want 1 2 203", o_en, o_addr, o_data); end
  endtask

  task automatic test_drop();
    do_reset();
    tick(0, 0, 0, 1, 0, 16'sh33, 0, 1, 0);
    n_checks++; if (o_br !== 1'b1) begin n_err++;
      $display("FAIL drop_ready0: got %0b want 1", o_br); end
    tick(0, 0, 0, 1, 4, 16'sh44, 0, 1, 4);
    n_checks++; if (o_br !== 1'b1 || o_en !== 1'b0 || o_drop !== 8'd1) begin n_err++;
      $display("FAIL drop_first: got ready=%0b en=%0b cnt=%0d want 1 0 1", o_br, o_en, o_drop); end
    idle(4);
    n_checks++; if (o_en !== 1'b0 || o_drop !== 8'd2) begin n_err++;
      $display("FAIL drop_second: got en=%0b cnt=%0d want 0 2", o_en, o_drop); end
    for (int i = 0; i < 300; i++) tick(0, 0, 0, 1, (i % 2) ? 3'd4 : 3'd0, 16'(i), 0, 1, 0);
    idle(0);
    n_checks++; if (o_drop !== 8'd255 || o_en !== 1'b0) begin n_err++;
      $display("FAIL drop_sat: got cnt=%0d en=%0b want 255 0", o_drop, o_en); end
  endtask

  task automatic test_stall();
    do_reset();
    tick(1, 7, 16'sh11, 0, 0, 0, 0, 1, 7);
    n_checks++; if (o_ar !== 1'b1) begin n_err++;
      $display("FAIL stall_accept: got %0b want 1", o_ar); end
    tick(1, 5, 16'sh55, 1, 6, 16'sh66, 1, 1, 7);
    n_checks++; if (o_ar !== 1'b0 || o_br !== 1'b0) begin n_err++;
      $display("FAIL stall_ready1: got a=%0b b=%0b want 0 0", o_ar, o_br); end
    n_checks++; if (o_en !== 1'b1 || o_addr !== 3'd7 || o_hit !== 1'b1 || o_byp !== 16'sh11) begin n_err++;
      $display("FAIL stall_issue: got en=%0b addr=%0d hit=%0b byp=%0h want 1 7 1 11", o_en, o_addr, o_hit, o_byp); end
    tick(1, 5, 16'sh55, 1, 6, 16'sh66, 1, 1, 7);
    n_checks++; if (o_ar !== 1'b0 || o_br !== 1'b0 || o_en !== 1'b0 || o_hit !== 1'b0 || o_byp !== '0) begin n_err++;
      $display("FAIL stall_hold: got a=%0b b=%0b en=%0b hit=%0b want 0 0 0 0", o_ar, o_br, o_en, o_hit); end
    tick(1, 5, 16'sh55, 1, 6, 16'sh66, 0, 1, 7);
    n_checks++; if (o_br !== 1'b1 || o_ar !== 1'b0) begin n_err++;
      $display("FAIL stall_release: got a=%0b b=%0b want 0 1", o_ar, o_br); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(0, 0, 0, 1, 0, 16'sh9, 0, 1, 0);
    tick(1, 5, 16'sh22, 0, 0, 0, 0, 1, 5);
    n_checks++; if (o_ar !== 1'b1) begin n_err++;
      $display("FAIL rmid_accept: got %0b want 1", o_ar); end
    tick(1, 5, 16'sh22, 1, 6, 16'sh66, 0, 0, 5);
    n_checks++; if (o_ar !== 1'b0 || o_br !== 1'b0 || o_hit !== 1'b0) begin n_err++;
      $display("FAIL rmid_during: got a=%0b b=%0b hit=%0b want 0 0 0", o_ar, o_br, o_hit); end
    tick(1, 5, 16'sh22, 1, 6, 16'sh66, 0, 1, 5);
    n_checks++; if (o_en !== 1'b0 || o_drop !== 8'd0) begin n_err++;
      $display("FAIL rmid_discard: got en=%0b cnt=%0d want 0 0", o_en, o_drop); end
    n_checks++; if (o_ar !== 1'b1 || o_br !== 1'b0) begin n_err++;
      $display("FAIL rmid_first_grant: got a=%0b b=%0b want 1 0", o_ar, o_br); end
  endtask

  task automatic test_random();
    logic [AW-1:0] qa;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      qa = ($urandom_range(0, 1) != 0) ? m_addr : AW'($urandom_range(0, R - 1));
      tick($urandom_range(0, 3) != 0, AW'($urandom_range(0, R - 1)), N'($urandom),
           $urandom_range(0, 3) != 0, AW'($urandom_range(0, R - 1)), N'($urandom),
           $urandom_range(0, 4) == 0, $urandom_range(0, 30) != 0, qa);
      n_checks++; if (o_ar !== e_ar || o_br !== e_br) begin n_err++;
        $display("FAIL rnd_ready@%0d: got a=%0b b=%0b want a=%0b b=%0b", i, o_ar, o_br, e_ar, e_br); end
      n_checks++; if (o_en !== e_en || o_addr !== e_addr || o_data !== e_data) begin n_err++;
        $display("FAIL rnd_wr@%0d: got %0b/%0d/%0h want %0b/%0d/%0h", i, o_en, o_addr, o_data, e_en, e_addr, e_data); end
      n_checks++; if (o_hit !== e_hit || o_byp !== e_byp) begin n_err++;
        $display("FAIL rnd_byp@%0d: got %0b/%0h want %0b/%0h", i, o_hit, o_byp, e_hit, e_byp); end
      n_checks++; if (o_drop !== e_drop) begin n_err++;
        $display("FAIL rnd_drop@%0d: got %0d want %0d", i, o_drop, e_drop); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_alternate();
    test_drop();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, want finish before 500000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rf_wb_arb.md
RF_WB_ARB -- requirements
Module: rf_wb_arb

Interface
REQ-001 SHALL take N (data width) and R (register count) from package pico; no module parameters.
REQ-002 SHALL have one clock and a synchronous, active-low reset: clk_i  in  1  rising-edge clock.
REQ-003 rst_ni  in  1  synchronous active-low reset.
REQ-004 a_valid_i  in  1  requester A (ALU writeback) has a write.
REQ-005 a_ready_o  out  1  requester A write accepted this cycle.
REQ-006 a_addr_i  in  $clog2(R)  A destination register; a_data_i  in  N (signed)  A write data.
REQ-007 b_valid_i  in  1; b_ready_o  out  1; b_addr_i  in  $clog2(R); b_data_i  in  N (signed): requester B (load/IO writeback), same meanings as A.
REQ-008 stall_i  in  1  when high, no new write is accepted.
REQ-009 wr_en_o  out  1; wr_addr_o  out  $clog2(R); wr_data_o  out  N (signed): register-file write port.
REQ-010 byp_addr_i  in  $clog2(R)  bypass query address.
REQ-011 byp_hit_o  out  1; byp_data_o  out  N (signed): forwarding of the in-flight write.
REQ-012 drop_cnt_o  out  8  count of discarded writes to reserved registers.

Function
REQ-013 Accept = valid_i AND ready_o in the same cycle; ready_o SHALL be combinational and high for at most one requester per cycle.
REQ-014 ready_o SHALL be low for both requesters whenever stall_i=1 or rst_ni=0.
REQ-015 Only A valid: grant A. Only B valid: grant B. Neither valid: no grant.
REQ-016 Both valid: grant the requester not granted last; last_grant register SHALL update only on an actual grant.
REQ-017 An accepted write SHALL appear on the write port exactly one cycle later: wr_en_o=1, wr_addr_o and wr_data_o equal to the accepted values.
REQ-018 wr_en_o SHALL be high for exactly one cycle per accepted non-reserved write. The register file never back-pressures, so the output stage drains every cycle.
REQ-019 Writes to register 0 (zero) or register 4 (external input) SHALL be accepted but SHALL NOT assert wr_en_o.
REQ-020 Each such dropped write SHALL increment drop_cnt_o by 1 on the following edge; drop_cnt_o saturates at 255.
REQ-021 When wr_en_o=0, wr_addr_o and wr_data_o SHALL be 0.
REQ-022 byp_hit_o = wr_en_o AND (wr_addr_o == byp_addr_i); combinational, no cycle delay.
REQ-023 byp_data_o = wr_data_o when byp_hit_o=1, else 0.
REQ-024 With stall_i=1, a write already in the output stage SHALL still issue; the cycle after, wr_en_o=0.
REQ-025 A valid_i dropped before acceptance SHALL NOT be written; there is no buffering beyond the single output stage.

Reset
REQ-026 On a clock edge with rst_ni=0: wr_en_o=0, wr_addr_o=0, wr_data_o=0, drop_cnt_o=0, last_grant=B (so A wins the first contention).
REQ-027 Reset asserted while a write is in the output stage SHALL discard it; it is never written.
REQ-028 During reset, byp_hit_o=0.

Structure
REQ-029 Package pico SHALL add constants ZERO_REG=0 and EXT_REG=4, and typedef wb_req_t {addr, data}; N and R remain there.
REQ-030 The two-way round-robin grant logic SHALL be sub-module rr_arb2 (req[1:0], gnt[1:0], last-grant state, clk_i/rst_ni).
REQ-031 Target size: 120-400 RTL lines including rr_arb2.

Verification
REQ-032 A valid, addr 3, data 0x5A, for one cycle -> a_ready_o=1 that cycle; next cycle wr_en_o=1, wr_addr_o=3, wr_data_o=0x5A; then wr_en_o=0.
REQ-033 Both valid for 4 cycles after reset (A addr 1, B addr 2) -> grants A,B,A,B; write port shows addr 1,2,1,2 one cycle delayed.
REQ-034 B writes addr 0, then addr 4 -> b_ready_o=1 both cycles; wr_en_o stays 0; drop_cnt_o goes 1 then 2. After 300 such writes, drop_cnt_o=255.
REQ-035 A accepted (addr 7, 0x11), then stall_i=1 with both valid -> addr 7 written next cycle; no ready for either requester while stalled. byp_addr_i=7 gives byp_hit_o=1, byp_data_o=0x11 only in the issue cycle.
REQ-036 A accepted, then rst_ni=0 on the next edge -> wr_en_o=0, drop_cnt_o=0. After release with both valid, A is granted first.
